// File: rtl/mult_arbiter.sv
// mult_arbiter: two-requester round-robin arbiter and sequencer for a shared
// shift-add multiplier datapath. It grants one requester, pulses load, runs
// n add/shift cycles steered by the multiplier LSB (Q0), then pulses done.
module mult_arbiter #(
    parameter int n = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       Q0,
    output logic [1:0] gnt,
    output logic       sel,
    output logic       load,
    output logic       add_shift,
    output logic       shift,
    output logic [1:0] done,
    output logic       busy
);

    localparam int CW = $clog2(n + 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        DONE
    } state_t;

    state_t         r_state;
    logic [CW-1:0]  r_cnt;
    logic [1:0]     r_gnt;
    logic           r_sel;
    logic           r_last;
    logic           r_load;
    logic           r_run;
    logic [1:0]     r_done;
    logic           r_busy;
    logic           w_win;

    // Round-robin winner: a lone request wins outright, a tie goes to the
    // requester that was not served last.
    always_comb begin
        w_win = 1'b0;
        case (req)
            2'b01:   w_win = 1'b0;
            2'b10:   w_win = 1'b1;
            2'b11:   w_win = ~r_last;
            default: w_win = 1'b0;
        endcase
    end

    // Sequencer: state, bit counter, grant and registered control outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_gnt   <= '0;
            r_sel   <= 1'b0;
            r_last  <= 1'b1;
            r_load  <= 1'b0;
            r_run   <= 1'b0;
            r_done  <= '0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req != 2'b00) begin
                        r_state <= LOAD;
                        r_gnt   <= {w_win, ~w_win};
                        r_sel   <= w_win;
                        r_load  <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                LOAD: begin
                    r_state <= RUN;
                    r_cnt   <= CW'(n);
                    r_load  <= 1'b0;
                    r_run   <= 1'b1;
                end
                RUN: begin
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == CW'(1)) begin
                        r_state <= DONE;
                        r_run   <= 1'b0;
                        r_done  <= r_gnt;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_last  <= r_sel;
                    r_gnt   <= '0;
                    r_sel   <= 1'b0;
                    r_done  <= '0;
                    r_busy  <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Q0 only matters while running; exactly one of add_shift/shift is high.
    assign add_shift = r_run & Q0;
    assign shift     = r_run & ~Q0;
    assign load      = r_load;
    assign done      = r_done;
    assign busy      = r_busy;
    assign gnt       = r_gnt;
    assign sel       = r_sel;

endmodule

// File: tb/tb_mult_arbiter.sv
// tb_mult_arbiter: directed and random stimulus against two instances
// (n=4 and n=1) sharing inputs, each checked against an operation-level model.
module tb_mult_arbiter;

    logic       clock = 1'b0;
    logic       reset;
    logic [1:0] req;
    logic       Q0;

    logic [1:0] gnt4, done4, gnt1, done1;
    logic       sel4, load4, as4, sh4, busy4;
    logic       sel1, load1, as1, sh1, busy1;

    int errors = 0;
    int checks = 0;

    // Operation model: per instance, whether an operation is active, who owns
    // it, which cycle of the operation we are in (1 = load ... n+2 = done),
    // and who was served last.
    int NN [2] = '{4, 1};
    int m_active [2];
    int m_owner  [2];
    int m_k      [2];
    int m_last   [2];

    mult_arbiter #(.n(4)) u_dut4 (
        .clock(clock), .reset(reset), .req(req), .Q0(Q0),
        .gnt(gnt4), .sel(sel4), .load(load4), .add_shift(as4),
        .shift(sh4), .done(done4), .busy(busy4)
    );

    mult_arbiter #(.n(1)) u_dut1 (
        .clock(clock), .reset(reset), .req(req), .Q0(Q0),
        .gnt(gnt1), .sel(sel1), .load(load1), .add_shift(as1),
        .shift(sh1), .done(done1), .busy(busy1)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input int id, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s n=%0d t=%0t observed=%0h expected=%0h", tag, NN[id], $time, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_active[i] = 0;
            m_owner[i]  = 0;
            m_k[i]      = 0;
            m_last[i]   = 1;
        end
    endtask

    // Advance the model across one rising edge using the req value seen there.
    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            if (m_active[i] == 0) begin
                if (req != 2'b00) begin
                    if (req == 2'b01)      m_owner[i] = 0;
                    else if (req == 2'b10) m_owner[i] = 1;
                    else                   m_owner[i] = (m_last[i] == 0) ? 1 : 0;
                    m_active[i] = 1;
                    m_k[i]      = 1;
                end
            end else if (m_k[i] == NN[i] + 2) begin
                m_active[i] = 0;
                m_last[i]   = m_owner[i];
            end else begin
                m_k[i] = m_k[i] + 1;
            end
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            logic [1:0] e_gnt, e_done;
            logic e_sel, e_load, e_run, e_busy;
            e_gnt = 2'b00; e_done = 2'b00; e_sel = 1'b0;
            e_load = 1'b0; e_run = 1'b0; e_busy = 1'b0;
            if (m_active[i] != 0) begin
                e_gnt  = (m_owner[i] == 1) ? 2'b10 : 2'b01;
                e_sel  = (m_owner[i] == 1);
                e_load = (m_k[i] == 1);
                e_run  = (m_k[i] >= 2) && (m_k[i] <= NN[i] + 1);
                e_done = (m_k[i] == NN[i] + 2) ? e_gnt : 2'b00;
                e_busy = 1'b1;
            end
            chk("gnt",       i, (i == 0) ? gnt4  : gnt1,  e_gnt);
            chk("sel",       i, (i == 0) ? sel4  : sel1,  e_sel);
            chk("load",      i, (i == 0) ? load4 : load1, e_load);
            chk("add_shift", i, (i == 0) ? as4   : as1,   e_run & Q0);
            chk("shift",     i, (i == 0) ? sh4   : sh1,   e_run & ~Q0);
            chk("done",      i, (i == 0) ? done4 : done1, e_done);
            chk("busy",      i, (i == 0) ? busy4 : busy1, e_busy);
        end
    endtask

    // One clock cycle: drive inputs after the falling edge, check, then let
    // the rising edge happen and advance the model.
    task automatic step(input logic [1:0] r, input logic q);
        @(negedge clock);
        req = r;
        Q0  = q;
        #1 check_all();
        @(posedge clock);
        if (!reset) model_edge();
    endtask

    task automatic release_reset();
        @(negedge clock);
        reset = 1'b0;
        req   = 2'b00;
        #1 check_all();
        @(posedge clock);
        model_edge();
    endtask

    task automatic sync_reset();
        @(negedge clock);
        reset = 1'b1;
        model_reset();
        #1 check_all();
        @(posedge clock);
        release_reset();
    endtask

    // Assert reset between edges: outputs must clear before the next edge.
    task automatic midcycle_reset();
        @(negedge clock);
        #1 check_all();
        #2 reset = 1'b1;
        model_reset();
        #1 check_all();
        @(posedge clock);
        release_reset();
    endtask

    initial begin
        reset = 1'b1;
        req   = 2'b00;
        Q0    = 1'b0;
        model_reset();
        @(negedge clock);
        #1 check_all();
        @(posedge clock);
        release_reset();

        // Single request on requester 0, Q0 bits 1,0,1,1 during RUN.
        step(2'b01, 1'b0);
        step(2'b01, 1'b1);
        step(2'b01, 1'b1);
        step(2'b01, 1'b0);
        step(2'b01, 1'b1);
        step(2'b01, 1'b1);
        step(2'b01, 1'b0);
        step(2'b00, 1'b1);
        step(2'b00, 1'b0);

        // Tie held from reset: grants alternate starting with requester 0.
        sync_reset();
        for (int c = 0; c < 30; c++) step(2'b11, 1'($urandom_range(0, 1)));
        step(2'b00, 1'b0);
        step(2'b00, 1'b0);

        // Requester 1 rises mid-operation; requester 0 finishes first.
        step(2'b01, 1'b1);
        step(2'b01, 1'b0);
        step(2'b11, 1'b1);
        for (int c = 0; c < 5; c++) step(2'b11, 1'($urandom_range(0, 1)));
        for (int c = 0; c < 8; c++) step(2'b10, 1'($urandom_range(0, 1)));
        step(2'b00, 1'b0);
        step(2'b00, 1'b0);

        // Requester 0 withdraws in the second RUN cycle; operation completes.
        step(2'b01, 1'b0);
        step(2'b01, 1'b1);
        step(2'b01, 1'b1);
        step(2'b00, 1'b0);
        for (int c = 0; c < 6; c++) step(2'b00, 1'($urandom_range(0, 1)));

        // Reset during the third RUN cycle, then a fresh request from 1.
        step(2'b01, 1'b0);
        step(2'b01, 1'b0);
        step(2'b01, 1'b1);
        step(2'b01, 1'b0);
        midcycle_reset();
        for (int c = 0; c < 7; c++) step(2'b10, 1'($urandom_range(0, 1)));
        step(2'b00, 1'b0);

        // Random traffic.
        for (int c = 0; c < 400; c++)
            step(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
